// File: rtl/sram_burst_reader.sv
// sram_burst_reader: read-side master for a single-port SRAM.
// Issues sequential reads starting at start_addr for `length` words. Each
// returned word goes into a small output FIFO, which is presented on a
// valid/ready stream. Reads are issued only when the FIFO has room for the
// word currently in flight plus the new one, so the FIFO can never overflow.

module sram_burst_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  // Burst request
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  // SRAM port
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic                  sram_enable,
  output logic                  sram_write,
  output logic [DATA_WIDTH-1:0] sram_write_data,
  input  logic [DATA_WIDTH-1:0] sram_read_data,
  // Output stream
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // One extra bit so the count can represent a full FIFO.
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;            // next address to read
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;  // reads not yet issued
  logic [ADDR_WIDTH-1:0]   sram_address_q, sram_address_d;
  logic                    sram_enable_q, sram_enable_d;
  logic                    done_q, done_d;

  // FIFO
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q;

  logic                    push;
  logic                    pop;
  logic                    credit_ok;

  // A read issued last edge returns its word this cycle; capture it now.
  assign push = sram_enable_q;
  assign pop  = (count_q != '0) && out_ready;

  // Room for the inflight word plus one more; a same-edge pop is not counted.
  assign credit_ok = (count_q + CNT_W'(sram_enable_q)) < DEPTH_C;

  // ---------------------------------------------------------------------------
  // Next-state and SRAM command logic
  // ---------------------------------------------------------------------------
  // Compute the next FSM state, read address, remaining count and done pulse.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and turn this block into latches.
    state_d        = state_q;
    addr_d         = addr_q;
    remaining_d    = remaining_q;
    sram_address_d = sram_address_q;
    sram_enable_d  = 1'b0;
    done_d         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            // Empty burst: acknowledge without touching the SRAM.
            done_d = 1'b1;
          end else if (credit_ok) begin
            // First read goes out on the accepting edge.
            sram_address_d = start_addr;
            sram_enable_d  = 1'b1;
            addr_d         = start_addr + ADDR_WIDTH'(1);
            remaining_d    = length - LEN_ONE;
            state_d        = (length == LEN_ONE) ? S_DRAIN : S_READ;
          end else begin
            addr_d      = start_addr;
            remaining_d = length;
            state_d     = S_READ;
          end
        end
      end

      S_READ: begin
        if (credit_ok) begin
          sram_address_d = addr_q;
          sram_enable_d  = 1'b1;
          addr_d         = addr_q + ADDR_WIDTH'(1);
          remaining_d    = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // Finish on the edge that pops the last word, so done and the fall
        // of busy appear in the cycle right after that pop.
        if (!sram_enable_q &&
            ((count_q == '0) || ((count_q == CNT_W'(1)) && pop))) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register FSM state, address/count and the SRAM command outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      remaining_q    <= '0;
      sram_address_q <= '0;
      sram_enable_q  <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      state_q        <= state_d;
      addr_q         <= addr_d;
      remaining_q    <= remaining_d;
      sram_address_q <= sram_address_d;
      sram_enable_q  <= sram_enable_d;
      done_q         <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  // Track write/read pointers and occupancy; push and pop may share an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Store the word returned by the SRAM into the slot at the write pointer.
  always_ff @(posedge clock) begin
    // NOTE: the storage array has no reset; emptiness is tracked by count_q,
    // so stale contents are never presented and need no clearing.
    if (push) begin
      fifo_mem[wr_ptr_q] <= sram_read_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign sram_address    = sram_address_q;
  assign sram_enable     = sram_enable_q;
  assign sram_write      = 1'b0;
  assign sram_write_data = '0;
  assign out_data        = fifo_mem[rd_ptr_q];
  assign out_valid       = (count_q != '0);

endmodule

// File: doc/sram_burst_reader.md
# sram_burst_reader

Read-side master for the generic single-port SRAM model. Given a start address and word count, it issues sequential read cycles on the SRAM port, captures each returned word into an internal FIFO and presents the words on a valid/ready stream. It sits between an SRAM instance and a downstream consumer, such as a CNN weight or input-feature loader.

## Interface

**Parameters**
- ADDR_WIDTH, 8, SRAM address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 16, SRAM word width.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.

**Ports**
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only while busy=0.
- start_addr  in  ADDR_WIDTH  first word address, sampled with start.
- length  in  ADDR_WIDTH+1  word count (0..2^ADDR_WIDTH), sampled with start.
- busy  out  1  high while a burst is active.
- done  out  1  one-cycle pulse at burst completion.
- sram_address  out  ADDR_WIDTH  registered address to the SRAM.
- sram_enable  out  1  registered; high for a cycle in which a read is issued.
- sram_write  out  1  constant 0.
- sram_write_data  out  DATA_WIDTH  constant 0.
- sram_read_data  in  DATA_WIDTH  SRAM combinational read data.
- out_data  out  DATA_WIDTH  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.

## Operation

**States**

IDLE
- start=1, length=0: done pulses on the next cycle; state stays IDLE; no SRAM read is issued.
- start=1, length≠0: load addr=start_addr and remaining=length; go to READ; the first read may be issued at this same edge (see issue rule).

READ
- On each edge where the issue rule holds: sram_address←addr, sram_enable←1, addr←addr+1 (wrapping), remaining←remaining−1.
- Otherwise sram_enable←0 and sram_address holds its value.
- When the last read is issued, go to DRAIN.

DRAIN
- Wait until there are no inflight reads and the FIFO is empty.
- Then pulse done, set busy←0 and return to IDLE.

**Issue rule**
- A read may be issued only if fifo_count + sram_enable < FIFO_DEPTH, where sram_enable is the current registered value, i.e. one read inflight.
- A pop on the same edge does not create credit (conservative).

**Capture**
- On any edge where sram_enable=1, push sram_read_data into the FIFO.
- Credit guarantees the FIFO is never pushed while full.

**Pop and busy**
- The FIFO pops when out_valid & out_ready; a push and a pop may occur on the same edge.
- busy=1 in READ and DRAIN. It rises on the edge that accepts a start with length≠0.
- start while busy=1 is ignored entirely.

**Reset (asynchronous)**
- State←IDLE, FIFO emptied, counters cleared.
- busy=0, done=0, sram_enable=0, sram_address=0, out_valid=0.
- Reset mid-burst discards inflight and buffered words; no done pulse is generated.

## Timing
- Clock period must exceed the SRAM read delay (4 time units). read_data is valid at the edge following issue.
- Edge E accepts start → address A0 is driven after E → word 0 is captured at E+1 → out_valid is high after E+1.
- With out_ready held at 1, the block sustains one word per cycle: N words occupy edges E..E+N−1 for issue, and out_valid is high from E+1 through E+N.
- done pulses for exactly one cycle, in the cycle after the edge on which the last word pops; busy falls together with done.
- sram_write and sram_write_data are never driven non-zero.

## Test plan
- **Basic burst:** preload mem[0x10..0x13]=0xA0..0xA3; start_addr=0x10, length=4, out_ready=1.
  - Expect out_data A0, A1, A2, A3 on consecutive cycles starting one cycle after start.
  - Expect one done pulse; sram_enable high for exactly 4 cycles.
- **Backpressure:** length=8, out_ready=0.
  - sram_enable stops after 4 issues (FIFO_DEPTH); out_valid holds with out_data = first word.
  - Release out_ready: all 8 words arrive in order, with no loss or duplication.
- **Wrap-around:** start_addr=0xFE, length=4.
  - sram_address sequence FE, FF, 00, 01; data matches the preloaded contents.
- **Zero length:** start with length=0.
  - done pulses one cycle later; busy stays 0; sram_enable is never asserted.
- **Start while busy:** second start during a length-6 burst.
  - Ignored: exactly 6 words and a single done pulse.
- **Reset mid-burst:** assert reset after 2 words.
  - All outputs go to their reset values immediately.
  - A following burst from 0x20, length 2, returns correct data.
